// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the burst SPI register memory.
package spi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_e;

  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;
  localparam logic        RW_READ  = 1'b1;

  function automatic logic mode_cpol(input int unsigned mode);
    return 1'((mode >> CPOL_BIT) & 32'd1);
  endfunction

  function automatic logic mode_cpha(input int unsigned mode);
    return 1'((mode >> CPHA_BIT) & 32'd1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Pin synchronisers and single-cycle SPI edge / chip-select event pulses.
module spi_sync_edge #(
  parameter int unsigned SPI_MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_i,
  input  logic cs_i,
  input  logic mosi_i,
  output logic mosi_o,
  output logic sample_edge_c_o,
  output logic shift_edge_c_o,
  output logic cs_fall_c_o,
  output logic cs_rise_c_o
);
  import spi_mem_pkg::*;

  localparam logic CPOL           = mode_cpol(SPI_MODE);
  localparam logic CPHA           = mode_cpha(SPI_MODE);
  localparam logic SAMPLE_ON_RISE = (CPOL == CPHA);

  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  logic       sclk_rise_c;
  logic       sclk_fall_c;

  // cs resets as "asserted" so a frame already running at release cannot start one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= {3{CPOL}};
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      cs_q   <= {cs_q[1:0], cs_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end

  assign sclk_rise_c     = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_c     = ~sclk_q[1] & sclk_q[2];
  assign sample_edge_c_o = SAMPLE_ON_RISE ? sclk_rise_c : sclk_fall_c;
  assign shift_edge_c_o  = SAMPLE_ON_RISE ? sclk_fall_c : sclk_rise_c;
  assign cs_fall_c_o     = ~cs_q[1] & cs_q[2];
  assign cs_rise_c_o     = cs_q[1] & ~cs_q[2];
  assign mosi_o          = mosi_q[1];

endmodule

// File: rtl/spi_memory_burst.sv
// SPI slave register memory: address+R/W command, then auto-incrementing burst words.
module spi_memory_burst #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned SPI_MODE = 0,
  parameter int unsigned LED_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_pin,
  input  logic             cs_pin,
  input  logic             mosi_pin,
  output logic             miso_pin,
  output logic             miso_oe,
  output logic [LED_W-1:0] leds
);
  import spi_mem_pkg::*;

  localparam int unsigned CNT_W   = $clog2(DATA_W + ADDR_W + 1);
  localparam int unsigned SHIFT_W = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic        CPHA    = mode_cpha(SPI_MODE);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SHIFT_W-2:0]  shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                miso_q, miso_d;
  logic                oe_q, oe_d;
  logic [LED_W-1:0]    leds_q, leds_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mosi_s;
  logic                sample_c, shift_c, cs_fall_c, cs_rise_c;
  logic [SHIFT_W-1:0]  shift_new_c;
  logic [ADDR_W-1:0]   cmd_addr_c, addr_inc_c, rd_addr_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic                wr_in_range_c;
  logic                mem_we_c;
  logic [DATA_W-1:0]   mem_wdata_c;

  spi_sync_edge #(.SPI_MODE(SPI_MODE)) u_sync (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk_i          (sclk_pin),
    .cs_i            (cs_pin),
    .mosi_i          (mosi_pin),
    .mosi_o          (mosi_s),
    .sample_edge_c_o (sample_c),
    .shift_edge_c_o  (shift_c),
    .cs_fall_c_o     (cs_fall_c),
    .cs_rise_c_o     (cs_rise_c)
  );

  assign shift_new_c   = {shift_q, mosi_s};
  assign cmd_addr_c    = shift_new_c[ADDR_W:1];
  assign addr_inc_c    = (32'(addr_q) == DEPTH - 1) ? '0 : addr_q + ADDR_W'(1);
  assign wr_in_range_c = 32'(addr_q) < DEPTH;
  // Single read port: the command address on entry to READ, else the next burst address
  assign rd_addr_c     = (state_q == CMD) ? cmd_addr_c : addr_inc_c;
  assign rd_word_c     = (32'(rd_addr_c) < DEPTH) ? mem_q[rd_addr_c[IDX_W-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      leds_q  <= leds_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[addr_q[IDX_W-1:0]] <= mem_wdata_c;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    leds_d      = leds_q;
    mem_we_c    = 1'b0;
    mem_wdata_c = shift_new_c[DATA_W-1:0];

    if (cs_rise_c) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall_c) begin
            state_d = CMD;
            cnt_d   = '0;
            shift_d = '0;
          end
        end

        CMD: begin
          if (sample_c) begin
            shift_d = shift_new_c[SHIFT_W-2:0];
            if (cnt_q == CNT_W'(ADDR_W)) begin
              cnt_d  = '0;
              addr_d = cmd_addr_c;
              if (shift_new_c[0] == RW_READ) begin
                state_d = READ;
                oe_d    = 1'b1;
                // CPHA=0 presents the MSB before the first data sample edge
                if (!CPHA) begin
                  miso_d  = rd_word_c[DATA_W-1];
                  rdata_d = {rd_word_c[DATA_W-2:0], 1'b0};
                end else begin
                  rdata_d = rd_word_c;
                end
              end else begin
                state_d = WRITE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        WRITE: begin
          if (sample_c) begin
            shift_d = shift_new_c[SHIFT_W-2:0];
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d  = '0;
              addr_d = addr_inc_c;
              if (wr_in_range_c) begin
                mem_we_c = 1'b1;
                leds_d   = shift_new_c[LED_W-1:0];
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        READ: begin
          if (sample_c) begin
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d  = '0;
              addr_d = addr_inc_c;
              if (!CPHA) begin
                miso_d  = rd_word_c[DATA_W-1];
                rdata_d = {rd_word_c[DATA_W-2:0], 1'b0};
              end else begin
                rdata_d = rd_word_c;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (shift_c && (CPHA || cnt_q != '0)) begin
            // With CPHA=0 the shift edge ahead of a word's first sample is already served
            miso_d  = rdata_q[DATA_W-1];
            rdata_d = {rdata_q[DATA_W-2:0], 1'b0};
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign miso_pin = miso_q;
  assign miso_oe  = oe_q;
  assign leds     = leds_q;

endmodule

// File: doc/spi_memory_burst.md
Name: spi_memory_burst

Overview:
Parametrised SPI slave register memory, the next generation of the single-byte SPI memory.
- Host sends a command of ADDR_W address bits, MSB first, followed by one R/W bit (1 = read).
- The block then writes or returns DATA_W-bit words. Burst transfer auto-increments the address, with wrap, while cs_pin stays low.
- Supports all four SPI modes. Includes pin synchronisers and a LED status view of the last written word.
- Sits between the board SPI pins and the user logic/LEDs.

Parameters:
ADDR_W, 7, address bits in the command frame
DATA_W, 8, bits per data word
DEPTH, 128, implemented words; must be <= 2**ADDR_W
SPI_MODE, 0, {CPOL,CPHA}: 0..3
LED_W, 4, width of the leds status output

Ports:
clk  in  1  system clock; all logic sampled on its rising edge
rst_n  in  1  reset, asynchronous assert, active-low
sclk_pin  in  1  SPI serial clock, asynchronous to clk
cs_pin  in  1  chip select, active-low, asynchronous
mosi_pin  in  1  serial data in
miso_pin  out  1  serial data out
miso_oe  out  1  high while a read word is being shifted out
leds  out  LED_W  low LED_W bits of the last completed write word

Behaviour:
- Reset (rst_n=0, async): state IDLE, miso_pin=0, miso_oe=0, leds=0, bit counter 0, address register 0. Memory contents are not cleared.
- Reset release: state stays IDLE until the synchronised cs is seen high and then falls. A frame already in progress at release is ignored.
- Sync: sclk, cs and mosi each pass through 2 flops. Edge detect uses a third flop on sclk.
  - Sample edge = rising sclk for modes 0/3, falling for modes 1/2. Shift edge is the opposite edge.
  - Host must hold each sclk phase for >= 2 clk periods.
  - miso changes within 3 clk of the pin-level shift edge.
- FSM states: IDLE, CMD, WRITE, READ.
  - IDLE -> CMD on synchronised cs falling edge. Clear the bit counter; load the shift register with 0.
  - CMD: shift mosi in on each sample edge, MSB first. After ADDR_W+1 samples, latch address = upper ADDR_W bits.
    - R/W=0 -> WRITE.
    - R/W=1 -> READ: load rdata = mem[addr] in the same clk cycle.
  - WRITE: shift in DATA_W bits. On the final sample edge, in the next clk:
    - write mem[addr] (if addr < DEPTH);
    - leds <= word[LED_W-1:0];
    - addr <= addr+1.
    - Stay in WRITE.
  - READ:
    - Modes 0/2 (CPHA=0): rdata MSB is driven before the first data sample edge (at command completion). Subsequent bits follow on shift edges.
    - Modes 1/3 (CPHA=1): each bit is driven on a shift edge.
    - miso_oe=1 throughout READ.
    - After DATA_W sample edges: addr <= addr+1, reload rdata = mem[new addr], continue (burst).
- Address wrap: increment from DEPTH-1 goes to 0.
- Out-of-range access: writes to addr >= DEPTH are dropped and leds is not updated. Reads return all zeros.
- cs rising (synchronised) in any state -> IDLE at the next clk.
  - A partial command or word is discarded; no memory write occurs.
  - miso_pin=0, miso_oe=0.
- Simultaneous cs rising and final write sample edge: cs wins; no write.
- Memory is a synchronous read/write array of DEPTH x DATA_W. Same-address write then immediate burst read returns the new data.

Decomposition:
- Package spi_mem_pkg:
  - state enum (IDLE, CMD, WRITE, READ);
  - SPI_MODE decode helper constants (CPOL/CPHA bit positions);
  - RW_READ = 1'b1.
- Sub-module spi_sync_edge: 2-flop synchronisers for sclk/cs/mosi plus sample_edge/shift_edge/cs_fall/cs_rise pulse generation, parametrised by SPI_MODE.
- Top holds the FSM, bit counter ($clog2(DATA_W+ADDR_W+1) bits), shift registers and the memory array.

Test Plan:
- Default params, mode 0: write 0xAA to address 0x1D, deassert cs, read 0x1D -> miso bits 1,0,1,0,1,0,1,0 on successive sample edges; leds=4'hA.
- Burst write 0x11,0x22,0x33 starting at 0x7E in one frame, then burst read 3 words from 0x7E -> 0x11,0x22,0x33; address wraps 0x7F -> 0x00, and mem[0x00]=0x33.
- SPI_MODE=3, DATA_W=16: write 0xBEEF to 0x05, read back -> 0xBEEF; miso_oe high only during the read data phase.
- cs raised after 5 data bits of a write to 0x10 (previously holding 0x5A) -> mem[0x10] still reads 0x5A; leds unchanged; state IDLE.
- DEPTH=100: write 0xFF to address 0x70 -> read returns 0x00; leds unchanged.
- rst_n pulsed low mid-read -> miso_pin=0 and miso_oe=0 immediately. Next full frame reading the previous write address returns correct data; memory is preserved.
